// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC select codes
// and default vectors used as parameter defaults by pc_seq.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_HOLD,
    SEL_TGT,
    SEL_RET,
    SEL_SEQ
  } pc_sel_e;

  localparam int unsigned PC_ADDR_W_DFLT    = 18;
  localparam int unsigned PC_STEP_DFLT      = 1;
  localparam int unsigned PC_RESET_VEC_DFLT = 'h0;
  localparam int unsigned PC_TRAP_VEC_DFLT  = 'h100;
  localparam int unsigned PC_RAS_DEPTH_DFLT = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, replace-top, entry count and a
// sticky overflow flag; a full push overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              ovf_o,
  output logic              err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [PTR_W-1:0]  top_ptr, nxt_ptr, waddr;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              we;

  // wp_q is the next free slot; the top entry sits one slot behind it.
  assign top_ptr = (wp_q == '0) ? PTR_W'(DEPTH - 1) : wp_q - 1'b1;
  assign nxt_ptr = (wp_q == PTR_W'(DEPTH - 1)) ? '0 : wp_q + 1'b1;

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    err_d = 1'b0;
    we    = 1'b0;
    waddr = wp_q;
    if (push_i && pop_i) begin
      we = 1'b1;
      if (cnt_q == '0) begin
        wp_d  = nxt_ptr;
        cnt_d = CNT_W'(1);
      end else begin
        waddr = top_ptr;
      end
    end else if (push_i) begin
      we   = 1'b1;
      wp_d = nxt_ptr;
      if (full_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end else if (pop_i) begin
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        wp_d  = top_ptr;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  assign empty_d = (cnt_d == '0);
  assign full_d  = (cnt_d == CNT_W'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= data_i;
  end

  assign top_o   = mem_q[top_ptr];
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign ovf_o   = ovf_q;
  assign err_o   = err_q;

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with trap/stall/branch priority select and an
// optional return-address stack enabled by macro PC_RAS_EN.
module pc_seq
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = PC_ADDR_W_DFLT,
  parameter int unsigned STEP      = PC_STEP_DFLT,
  parameter int unsigned RESET_VEC = PC_RESET_VEC_DFLT,
  parameter int unsigned TRAP_VEC  = PC_TRAP_VEC_DFLT,
  parameter int unsigned RAS_DEPTH = PC_RAS_DEPTH_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              trap,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ret_err
);

  if (RAS_DEPTH < 2 || RAS_DEPTH > 16) begin : g_depth_chk
    $error("pc_seq: RAS_DEPTH must be within 2..16");
  end

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] ras_top;
  logic              tgt_req;
  logic              ret_req;
  pc_sel_e           sel;

  assign pc_inc = pc_q + ADDR_W'(STEP);

`ifdef PC_RAS_EN
  logic active;
  logic ras_push;
  logic ras_pop;

  // Trap and stall both block every stack side effect for the cycle.
  assign active   = ~trap & ~stall;
  assign ras_push = active & call;
  assign ras_pop  = active & ret;

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_inc),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full),
    .ovf_o   (ras_ovf),
    .err_o   (ret_err)
  );

  assign tgt_req = call | br_taken;
  assign ret_req = ret & ~ras_empty;
`else
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ret_err   = 1'b0;
  assign tgt_req   = call | br_taken | ret;
  assign ret_req   = 1'b0;
`endif

  always_comb begin
    sel = SEL_SEQ;
    if (trap)         sel = SEL_TRAP;
    else if (stall)   sel = SEL_HOLD;
    else if (tgt_req) sel = SEL_TGT;
    else if (ret_req) sel = SEL_RET;
  end

  always_comb begin
    pc_d = pc_inc;
    case (sel)
      SEL_TRAP: pc_d = ADDR_W'(TRAP_VEC);
      SEL_HOLD: pc_d = pc_q;
      SEL_TGT:  pc_d = br_target;
      SEL_RET:  pc_d = ras_top;
      SEL_SEQ:  pc_d = pc_inc;
      default:  pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= ADDR_W'(RESET_VEC);
    else     pc_q <= pc_d;
  end

  assign pc      = pc_q;
  assign pc_next = pc_d;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: stimulus pushes model expectations, a monitor
// pops and compares them every cycle; follows the PC_RAS_EN build choice.
module tb_pc_seq;

  localparam int ADDR_W = 18;
  localparam int STEP   = 1;
  localparam int RV     = 0;
  localparam int TV     = 'h100;
  localparam int DEPTH  = 4;
  localparam int MASK   = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0, trap = 1'b0, br_taken = 1'b0;
  logic              call = 1'b0, ret = 1'b0;
  logic [ADDR_W-1:0] br_target = '0;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              ras_empty, ras_full, ras_ovf, ret_err;

  pc_seq #(
    .ADDR_W    (ADDR_W),
    .STEP      (STEP),
    .RESET_VEC (RV),
    .TRAP_VEC  (TV),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .trap      (trap),
    .br_taken  (br_taken),
    .br_target (br_target),
    .call      (call),
    .ret       (ret),
    .pc        (pc),
    .pc_next   (pc_next),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ret_err   (ret_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nxt;
    bit emp;
    bit full;
    bit ovf;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int   m_pc = RV;
  int   stk[$];
  bit   m_ovf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drives one cycle of inputs, predicts, queues.
  task automatic step(input bit t, input bit s, input bit b, input bit c,
                      input bit r, input int tgt);
    exp_t e;
    int   seq;
    int   nxt;
    bit   err;
    err = 1'b0;
    tgt = tgt & MASK;
    trap = t; stall = s; br_taken = b; call = c; ret = r;
    br_target = ADDR_W'(tgt);
    seq = (m_pc + STEP) & MASK;
`ifdef PC_RAS_EN
    if (t)                nxt = TV;
    else if (s)           nxt = m_pc;
    else if (c && r) begin
      if (stk.size() == 0) stk.push_back(seq);
      else                 stk[stk.size()-1] = seq;
      nxt = tgt;
    end else if (c) begin
      if (stk.size() == DEPTH) begin
        void'(stk.pop_front());
        m_ovf = 1'b1;
      end
      stk.push_back(seq);
      nxt = tgt;
    end else if (r) begin
      if (stk.size() == 0) begin
        err = 1'b1;
        nxt = b ? tgt : seq;
      end else begin
        int popped;
        popped = stk.pop_back();
        nxt = b ? tgt : popped;
      end
    end else if (b)       nxt = tgt;
    else                  nxt = seq;
    e.emp  = (stk.size() == 0);
    e.full = (stk.size() == DEPTH);
    e.ovf  = m_ovf;
    e.err  = err;
`else
    if (t)                nxt = TV;
    else if (s)           nxt = m_pc;
    else if (b || c || r) nxt = tgt;
    else                  nxt = seq;
    e.emp  = 1'b1;
    e.full = 1'b0;
    e.ovf  = 1'b0;
    e.err  = 1'b0;
`endif
    e.nxt = nxt;
    m_pc  = nxt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // Monitor: pc_next sampled before the edge, registered outputs after it.
  initial begin
    int   nx;
    exp_t e;
    forever begin
      @(negedge clk);
      #2 nx = int'(pc_next);
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_next", nx, e.nxt);
        chk("pc", int'(pc), e.nxt);
        chk("ras_empty", int'(ras_empty), int'(e.emp));
        chk("ras_full", int'(ras_full), int'(e.full));
        chk("ras_ovf", int'(ras_ovf), int'(e.ovf));
        chk("ret_err", int'(ret_err), int'(e.err));
      end
    end
  end

  initial begin
    #3;
    chk("rst_pc", int'(pc), RV);
    chk("rst_empty", int'(ras_empty), 1);
    chk("rst_full", int'(ras_full), 0);
    chk("rst_ovf", int'(ras_ovf), 0);
    chk("rst_err", int'(ret_err), 0);

    @(negedge clk);
    rst = 1'b0;
    idle(3);

    step(0, 0, 1, 0, 0, 'h3FFFF);
    idle(2);

    step(0, 0, 1, 0, 0, 10);
    step(0, 0, 0, 1, 0, 50);
    idle(2);
    step(0, 0, 0, 0, 1, 77);
    idle(1);

    for (int i = 1; i <= 5; i++) step(0, 0, 0, 1, 0, i * 1000);
    for (int i = 0; i < 5; i++)  step(0, 0, 0, 0, 1, 'h2222);
    idle(1);

    step(0, 0, 0, 1, 0, 300);
    step(1, 1, 0, 1, 1, 400);
    step(0, 1, 1, 1, 0, 500);
    step(0, 1, 0, 0, 1, 600);
    step(0, 1, 0, 1, 1, 700);
    step(0, 0, 0, 0, 1, 800);
    step(0, 0, 0, 0, 1, 900);
    step(0, 1, 0, 0, 1, 901);
    step(0, 0, 1, 0, 1, 902);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(15) == 0, $urandom_range(5) == 0,
           $urandom_range(4) == 0, $urandom_range(3) == 0,
           $urandom_range(3) == 0, int'($urandom));
    end
    drain();

    call = 1'b1;
    br_target = ADDR_W'(123);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_pc", int'(pc), RV);
    chk("async_rst_empty", int'(ras_empty), 1);
    chk("async_rst_ovf", int'(ras_ovf), 0);
    chk("async_rst_err", int'(ret_err), 0);
    call = 1'b0;
    m_pc = RV;
    stk.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    step(0, 0, 0, 0, 1, 55);
    idle(1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
